// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready on both sides.
// Define SHIFT_PIPE_OVF_EN to build the SLL lost-bit (out_ovf) tracking; otherwise out_ovf is 0.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_ovf
);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  localparam int LAST = SHAMT_W - 1;

  logic en;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input op_e op,
                                                input int unsigned n);
    logic [WIDTH-1:0] r;
    r = d;
    unique case (op)
      OP_SLL:  r = d << n;
      OP_SRL:  r = d >> n;
      OP_SRA:  r = $unsigned($signed(d) >>> n);
      OP_ROTL: r = (d << n) | (d >> (WIDTH - n));
      default: r = d;
    endcase
    return r;
  endfunction

  // The whole pipe advances or holds as one; bubbles are not squeezed out.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int unsigned STEP = 1 << k;

    logic                   v_i;
    logic [WIDTH-1:0]       d_i;
    op_e                    op_i;
    logic [TAG_W-1:0]       tag_i;
    // Only the shamt bits this stage and later stages still need; bit 0 is shamt bit k.
    logic [SHAMT_W-1-k:0]   sh_i;

    logic                   valid_q;
    logic [WIDTH-1:0]       data_q;
    logic [TAG_W-1:0]       tag_q;

    if (k == 0) begin : g_src
      assign v_i   = in_valid;
      assign d_i   = in_data;
      assign op_i  = op_e'(in_op);
      assign tag_i = in_tag;
      assign sh_i  = in_shamt;
    end else begin : g_src
      assign v_i   = g_stage[k-1].valid_q;
      assign d_i   = g_stage[k-1].data_q;
      assign op_i  = g_stage[k-1].g_fwd.op_q;
      assign tag_i = g_stage[k-1].tag_q;
      assign sh_i  = g_stage[k-1].g_fwd.shamt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; datapath registers are reset as well so out_* read 0.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (en) begin
        valid_q <= v_i;
        data_q  <= sh_i[0] ? shift_by(d_i, op_i, STEP) : d_i;
        tag_q   <= tag_i;
      end
    end

    // Op and remaining shamt bits are only needed by later stages.
    if (k < LAST) begin : g_fwd
      op_e                    op_q;
      logic [SHAMT_W-2-k:0]   shamt_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          op_q    <= OP_SLL;
          shamt_q <= '0;
        end else if (en) begin
          op_q    <= op_i;
          shamt_q <= sh_i[SHAMT_W-1-k:1];
        end
      end
    end

`ifdef SHIFT_PIPE_OVF_EN
    logic ovf_i;
    logic ovf_q;

    if (k == 0) begin : g_ovf_src
      assign ovf_i = 1'b0;
    end else begin : g_ovf_src
      assign ovf_i = g_stage[k-1].ovf_q;
    end

    // Bits pushed out past the MSB by this stage's left shift.
    always_ff @(posedge clk) begin
      if (reset) begin
        ovf_q <= 1'b0;
      end else if (en) begin
        ovf_q <= ovf_i | (sh_i[0] && (op_i == OP_SLL) && (|d_i[WIDTH-1 -: STEP]));
      end
    end
`endif
  end

  assign out_valid = g_stage[LAST].valid_q;
  assign out_data  = g_stage[LAST].data_q;
  assign out_tag   = g_stage[LAST].tag_q;

`ifdef SHIFT_PIPE_OVF_EN
  assign out_ovf = g_stage[LAST].ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed steps plus random traffic against a whole-shift arithmetic
// model and an in-order scoreboard.
module tb_shift_pipe;
  localparam int WIDTH   = 32;
  localparam int TAG_W   = 4;
  localparam int SHAMT_W = 5;
`ifdef SHIFT_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_ovf;

  typedef struct packed {
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Whole-amount shift computed directly from the op definitions.
  function automatic beat_t model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                                  input logic [3:0] tag);
    beat_t b;
    b.tag = tag;
    b.ovf = 1'b0;
    case (op)
      2'd0: begin
        b.data = d << s;
        b.ovf  = OVF_EN && ((d >> (32 - int'(s))) != 32'h0);
      end
      2'd1:    b.data = d >> s;
      2'd2:    b.data = (d >> s) | (d[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: b.data = (d << s) | (d >> (32 - int'(s)));
    endcase
    return b;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] op, input logic [3:0] tag, input logic rdy,
                       input logic rst);
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    in_tag    = tag;
    out_ready = rdy;
    reset     = rst;
  endtask

  // Score the handshakes that will happen on the coming edge, then advance to the next negedge.
  task automatic sample_tick();
    beat_t e;
    #1;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_tag", out_tag, e.tag);
        check("sb_ovf", out_ovf, e.ovf);
      end
    end
    if (!reset && in_valid && in_ready)
      exp_q.push_back(model(in_data, in_shamt, in_op, in_tag));
    @(posedge clk);
    if (reset) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s,
                      input logic [1:0] op, input logic [3:0] tag, input logic rdy,
                      input logic rst);
    drive(v, d, s, op, tag, rdy, rst);
    sample_tick();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 5'd0, 2'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    check(name, exp_q.size(), 0);
  endtask

  // Send one beat into an empty pipe and return its result.
  task automatic run_one(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                         input logic [3:0] tag, output logic [31:0] rd, output logic rov);
    step(1'b1, d, s, op, tag, 1'b1, 1'b0);
    for (int i = 0; i < 12 && !out_valid; i++) idle();
    check("run_one_valid", out_valid, 1'b1);
    rd  = out_data;
    rov = out_ovf;
    idle();
  endtask

  initial begin
    logic [31:0] rd;
    logic        rov;

    // Reset, with a beat presented that must not be accepted.
    step(1'b1, 32'h1234, 5'd3, 2'd0, 4'hF, 1'b0, 1'b1);
    step(1'b1, 32'h1234, 5'd3, 2'd0, 4'hF, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_ovf", out_ovf, 1'b0);

    // Basic SLL: latency and tag.
    step(1'b1, 32'h0000_0001, 5'd2, 2'd0, 4'd3, 1'b1, 1'b0);
    for (int j = 0; j <= 4; j++) begin
      check("lat_valid", out_valid, (j == 4));
      if (j == 4) begin
        check("lat_data", out_data, 32'h0000_0004);
        check("lat_tag", out_tag, 4'd3);
      end
      idle();
    end

    // Right shifts, rotate, identity.
    run_one(32'h8000_0000, 5'd31, 2'd2, 4'd1, rd, rov);
    check("sra_31", rd, 32'hFFFF_FFFF);
    run_one(32'h8000_0000, 5'd31, 2'd1, 4'd2, rd, rov);
    check("srl_31", rd, 32'h0000_0001);
    run_one(32'h8000_0001, 5'd4, 2'd3, 4'd5, rd, rov);
    check("rotl_4", rd, 32'h0000_0018);
    for (int op = 0; op < 4; op++) begin
      run_one(32'hDEAD_BEEF, 5'd0, 2'(op), 4'(op), rd, rov);
      check("shamt0_identity", rd, 32'hDEAD_BEEF);
    end

    // Five back-to-back SLL beats come out on consecutive cycles.
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i), 5'd1, 2'd0, 4'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stream_valid", out_valid, 1'b1);
      check("stream_data", out_data, 32'(2 * i));
      check("stream_tag", out_tag, 4'(i));
      idle();
    end
    check("stream_end_valid", out_valid, 1'b0);

    // Stall mid-stream for three cycles.
    for (int i = 0; i < 6; i++)
      step(1'b1, $urandom, 5'($urandom), 2'($urandom), 4'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'($urandom), 2'($urandom), 4'hE, 1'b0, 1'b0);
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_hold_data", out_data, exp_q[0].data);
      check("stall_hold_tag", out_tag, exp_q[0].tag);
      sample_tick();
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom, 5'($urandom), 2'($urandom), 4'(8 + i), 1'b1, 1'b0);
    drain("stall_drain");

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, 5'($urandom), 2'($urandom), 4'(i), 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 5'd1, 2'd0, 4'h7, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) idle();
    check("midrst_quiet", out_valid, 1'b0);

    // Overflow tracking.
    run_one(32'h4000_0000, 5'd2, 2'd0, 4'd9, rd, rov);
    check("ovf_data", rd, 32'h0000_0000);
    check("ovf_flag", rov, OVF_EN);
    run_one(32'h0000_0001, 5'd31, 2'd0, 4'd10, rd, rov);
    check("noovf_data", rd, 32'h8000_0000);
    check("noovf_flag", rov, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 2'($urandom), 4'($urandom),
           $urandom_range(0, 3) != 0, 1'b0);
    drain("rand_drain");
    check("final_out_valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
